// File: rtl/cp1_issue_ctrl.sv
// CP1 command issue controller: hands COP1 commands from the pipeline to the coprocessor and returns one response.
// Optional REQ timeout is compiled in with CP1_TIMEOUT_EN; the default build waits for cp_ack indefinitely.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a command, no stall
// ST_REQ  | cp_req held with stable cp_inst/cp_wdata until cp_ack
// ST_RESP | one-cycle resp_valid strobe, then back to IDLE
module cp1_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_inst,
    input  logic [31:0] cmd_wdata,
    output logic        cmd_ready,
    output logic        stall,
    output logic        cp_req,
    output logic [31:0] cp_inst,
    output logic [31:0] cp_wdata,
    input  logic        cp_ack,
    input  logic [31:0] cp_rdata,
    input  logic [7:0]  cp_flags,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [7:0]  resp_flags,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [5:0] OP_COP1 = 6'b010001;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cp1_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [31:0] cp_inst_q, cp_inst_d;
    logic [31:0] cp_wdata_q, cp_wdata_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [7:0]  resp_flags_q, resp_flags_d;
    logic        resp_err_q, resp_err_d;

`ifdef CP1_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        cp_inst_d    = cp_inst_q;
        cp_wdata_d   = cp_wdata_q;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;
        resp_err_d   = resp_err_q;
`ifdef CP1_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_inst[31:26] == OP_COP1) begin
                        cp_inst_d  = cmd_inst;
                        cp_wdata_d = cmd_wdata;
                        state_d    = ST_REQ;
`ifdef CP1_TIMEOUT_EN
                        tmo_cnt_d  = '0;
`endif
                    end else begin
                        resp_data_d  = '0;
                        resp_flags_d = '0;
                        resp_err_d   = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                // cp_ack wins over a timeout landing in the same cycle
                if (cp_ack) begin
                    resp_data_d  = (cp_inst_q[25:21] == 5'b00000) ? cp_rdata : '0;
                    resp_flags_d = cp_flags;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                end
`ifdef CP1_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    resp_data_d  = '0;
                    resp_flags_d = '0;
                    resp_err_d   = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cp_inst_q    <= '0;
            cp_wdata_q   <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef CP1_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cp_inst_q    <= cp_inst_d;
            cp_wdata_q   <= cp_wdata_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
            resp_err_q   <= resp_err_d;
`ifdef CP1_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign stall      = (state_q != ST_IDLE);
    assign cp_req     = (state_q == ST_REQ);
    assign resp_valid = (state_q == ST_RESP);
    assign cp_inst    = cp_inst_q;
    assign cp_wdata   = cp_wdata_q;
    assign resp_data  = resp_data_q;
    assign resp_flags = resp_flags_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_cp1_issue_ctrl.sv
// Directed bench for cp1_issue_ctrl; covers the timeout path when built with CP1_TIMEOUT_EN.
module tb_cp1_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_inst;
    logic [31:0] cmd_wdata;
    logic        cmd_ready;
    logic        stall;
    logic        cp_req;
    logic [31:0] cp_inst;
    logic [31:0] cp_wdata;
    logic        cp_ack;
    logic [31:0] cp_rdata;
    logic [7:0]  cp_flags;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [7:0]  resp_flags;
    logic        resp_err;

    int n_chk  = 0;
    int n_fail = 0;
    int rv_cnt = 0;

    cp1_issue_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_inst   (cmd_inst),
        .cmd_wdata  (cmd_wdata),
        .cmd_ready  (cmd_ready),
        .stall      (stall),
        .cp_req     (cp_req),
        .cp_inst    (cp_inst),
        .cp_wdata   (cp_wdata),
        .cp_ack     (cp_ack),
        .cp_rdata   (cp_rdata),
        .cp_flags   (cp_flags),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_flags (resp_flags),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // number of completed cycles with resp_valid high
    always @(posedge clk) if (resp_valid === 1'b1) rv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_inst  = inst;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int rv0;
        int low;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_inst  = '0;
        cmd_wdata = '0;
        cp_ack    = 1'b0;
        cp_rdata  = '0;
        cp_flags  = '0;
        tick();
        tick();

        chk("rst_cp_req",     32'(cp_req), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_err",   32'(resp_err), 0);
        chk("rst_stall",      32'(stall), 0);
        chk("rst_cmd_ready",  32'(cmd_ready), 1);
        chk("rst_cp_inst",    cp_inst, 0);
        chk("rst_cp_wdata",   cp_wdata, 0);
        chk("rst_resp_data",  resp_data, 0);
        chk("rst_resp_flags", 32'(resp_flags), 0);
        rst = 1'b0;
        tick();

        // MFC1 with ack on the third REQ cycle
        rv0 = rv_cnt;
        send(32'h4402_0800, 32'h1234_5678);
        chk("mfc_req1_cp_req",    32'(cp_req), 1);
        chk("mfc_req1_stall",     32'(stall), 1);
        chk("mfc_req1_cmd_ready", 32'(cmd_ready), 0);
        chk("mfc_req1_cp_inst",   cp_inst, 32'h4402_0800);
        tick();
        chk("mfc_req2_cp_req",    32'(cp_req), 1);
        chk("mfc_req2_rv",        32'(resp_valid), 0);
        tick();
        chk("mfc_req3_cp_req",    32'(cp_req), 1);
        cp_ack   = 1'b1;
        cp_rdata = 32'h3F80_0000;
        cp_flags = 8'h01;
        tick();
        cp_ack   = 1'b0;
        cp_rdata = 32'hFFFF_FFFF;
        chk("mfc_resp_valid",  32'(resp_valid), 1);
        chk("mfc_resp_data",   resp_data, 32'h3F80_0000);
        chk("mfc_resp_flags",  32'(resp_flags), 32'h01);
        chk("mfc_resp_err",    32'(resp_err), 0);
        chk("mfc_resp_cp_req", 32'(cp_req), 0);
        chk("mfc_resp_stall",  32'(stall), 1);
        tick();
        chk("mfc_idle_rv",     32'(resp_valid), 0);
        chk("mfc_idle_stall",  32'(stall), 0);
        chk("mfc_idle_ready",  32'(cmd_ready), 1);
        chk("mfc_hold_data",   resp_data, 32'h3F80_0000);
        chk("mfc_pulses",      32'(rv_cnt - rv0), 1);

        // stray cp_ack in IDLE must do nothing
        cp_ack = 1'b1;
        tick();
        cp_ack = 1'b0;
        chk("stray_ack_ready", 32'(cmd_ready), 1);
        chk("stray_ack_req",   32'(cp_req), 0);
        tick();
        chk("stray_ack_rv",    32'(resp_valid), 0);
        chk("stray_ack_pulses", 32'(rv_cnt - rv0), 1);

        // MTC1 with ack in the first REQ cycle: minimum latency
        send(32'h4482_1000, 32'hDEAD_BEEF);
        chk("mtc_cp_req",   32'(cp_req), 1);
        chk("mtc_cp_wdata", cp_wdata, 32'hDEAD_BEEF);
        cp_ack   = 1'b1;
        cp_rdata = 32'hAAAA_5555;
        cp_flags = 8'h80;
        tick();
        cp_ack = 1'b0;
        chk("mtc_resp_valid", 32'(resp_valid), 1);
        chk("mtc_resp_data",  resp_data, 0);
        chk("mtc_resp_flags", 32'(resp_flags), 32'h80);
        chk("mtc_resp_err",   32'(resp_err), 0);
        tick();

        // non-COP1 command
        send(32'h0000_0020, 32'h0000_0001);
        chk("ill_resp_valid", 32'(resp_valid), 1);
        chk("ill_resp_err",   32'(resp_err), 1);
        chk("ill_cp_req",     32'(cp_req), 0);
        chk("ill_resp_data",  resp_data, 0);
        chk("ill_resp_flags", 32'(resp_flags), 0);
        tick();
        chk("ill_idle_ready", 32'(cmd_ready), 1);
        chk("ill_hold_err",   32'(resp_err), 1);

        // reset in the middle of REQ, late cp_ack must not respond
        rv0 = rv_cnt;
        send(32'h4403_0800, 32'h0);
        tick();
        chk("abort_req2_cp_req", 32'(cp_req), 1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        cp_ack   = 1'b1;
        cp_rdata = 32'h0BAD_0BAD;
        cp_flags = 8'h44;
        chk("abort_cp_req", 32'(cp_req), 0);
        chk("abort_stall",  32'(stall), 0);
        chk("abort_ready",  32'(cmd_ready), 1);
        tick();
        cp_ack = 1'b0;
        chk("abort_rv",     32'(resp_valid), 0);
        tick();
        chk("abort_pulses", 32'(rv_cnt - rv0), 0);
        chk("abort_data",   resp_data, 0);

        // back-to-back COP1 commands, second one waits on cmd_valid through REQ/RESP
        rv0 = rv_cnt;
        send(32'h4403_0800, 32'h0);
        cmd_valid = 1'b1;
        cmd_inst  = 32'h4404_0800;
        cmd_wdata = 32'h0000_00B2;
        chk("b2b_a_cp_inst", cp_inst, 32'h4403_0800);
        cp_ack   = 1'b1;
        cp_rdata = 32'h1111_1111;
        cp_flags = 8'h10;
        tick();
        cp_ack = 1'b0;
        chk("b2b_a_rv",     32'(resp_valid), 1);
        chk("b2b_a_data",   resp_data, 32'h1111_1111);
        chk("b2b_a_stall",  32'(stall), 1);
        chk("b2b_a_ready",  32'(cmd_ready), 0);
        tick();
        chk("b2b_gap_stall", 32'(stall), 0);
        chk("b2b_gap_ready", 32'(cmd_ready), 1);
        chk("b2b_gap_rv",    32'(resp_valid), 0);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_b_cp_inst", cp_inst, 32'h4404_0800);
        chk("b2b_b_wdata",   cp_wdata, 32'h0000_00B2);
        chk("b2b_b_stall",   32'(stall), 1);
        cp_ack   = 1'b1;
        cp_rdata = 32'h2222_2222;
        cp_flags = 8'h20;
        tick();
        cp_ack = 1'b0;
        chk("b2b_b_rv",     32'(resp_valid), 1);
        chk("b2b_b_data",   resp_data, 32'h2222_2222);
        chk("b2b_b_flags",  32'(resp_flags), 32'h20);
        tick();
        chk("b2b_pulses",   32'(rv_cnt - rv0), 2);

`ifdef CP1_TIMEOUT_EN
        // no ack: four REQ cycles then an error response
        send(32'h4405_0800, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tmo_req%0d_cp_req", i + 1), 32'(cp_req), 1);
            tick();
        end
        chk("tmo_resp_valid", 32'(resp_valid), 1);
        chk("tmo_resp_err",   32'(resp_err), 1);
        chk("tmo_resp_data",  resp_data, 0);
        chk("tmo_resp_flags", 32'(resp_flags), 0);
        tick();
        chk("tmo_idle_ready", 32'(cmd_ready), 1);

        // ack in the timeout cycle wins
        send(32'h4406_0800, 32'h0);
        tick();
        tick();
        tick();
        chk("tmo_pri_cp_req", 32'(cp_req), 1);
        cp_ack   = 1'b1;
        cp_rdata = 32'h0000_0055;
        cp_flags = 8'h02;
        tick();
        cp_ack = 1'b0;
        chk("tmo_pri_rv",    32'(resp_valid), 1);
        chk("tmo_pri_err",   32'(resp_err), 0);
        chk("tmo_pri_data",  resp_data, 32'h0000_0055);
        chk("tmo_pri_flags", 32'(resp_flags), 32'h02);
        tick();
`else
        // no ack and no timeout: the request stays open
        rv0 = rv_cnt;
        low = 0;
        send(32'h4405_0800, 32'h0);
        for (int i = 0; i < 100; i++) begin
            if (stall !== 1'b1) low++;
            tick();
        end
        chk("hang_stall_low_cycles", 32'(low), 0);
        chk("hang_cp_req",  32'(cp_req), 1);
        chk("hang_pulses",  32'(rv_cnt - rv0), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hang_rst_ready", 32'(cmd_ready), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp1_issue_ctrl.md
CP1_ISSUE_CTRL -- requirements
Module: cp1_issue_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles in REQ awaiting cp_ack (used only with CP1_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  pipeline presents a CP1 command.
REQ-005 cmd_inst  input  32  instruction word.
REQ-006 cmd_wdata  input  32  GPR operand (MTC1 source).
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 stall  output  1  pipeline hold request.
REQ-009 cp_req  output  1  request to coprocessor.
REQ-010 cp_inst  output  32  instruction to coprocessor.
REQ-011 cp_wdata  output  32  data to coprocessor.
REQ-012 cp_ack  input  1  coprocessor completion strobe.
REQ-013 cp_rdata  input  32  coprocessor result (MFC1).
REQ-014 cp_flags  input  8  coprocessor status flags.
REQ-015 resp_valid  output  1  one-cycle response strobe.
REQ-016 resp_data  output  32  returned data.
REQ-017 resp_flags  output  8  returned flags.
REQ-018 resp_err  output  1  command illegal or timed out.

Function
REQ-019 FSM states SHALL be IDLE, REQ and RESP.
REQ-020 cmd_ready SHALL be 1 only in IDLE; accept = cmd_valid & cmd_ready at a rising edge.
REQ-021 A command is COP1 iff cmd_inst[31:26] == 6'b010001.
REQ-022 Accepted COP1 command: capture cmd_inst and cmd_wdata into cp_inst/cp_wdata; IDLE->REQ; cp_req = 1 from the next cycle.
REQ-023 Accepted non-COP1 command: IDLE->RESP with resp_err = 1, resp_data = 0, resp_flags = 0; cp_req stays 0.
REQ-024 In REQ, cp_req, cp_inst and cp_wdata SHALL remain stable until cp_ack is sampled high.
REQ-025 cp_ack sampled high in REQ: capture resp_data (cp_rdata if rs field cmd_inst[25:21] == 5'b00000 (MFC1), else 0) and cp_flags; REQ->RESP.
REQ-026 cp_ack high in the first REQ cycle SHALL be honoured, giving minimum latency accept edge N -> resp_valid in cycle N+2.
REQ-027 RESP lasts exactly one cycle with resp_valid = 1; then RESP->IDLE; cp_req = 0 in RESP.
REQ-028 resp_data, resp_flags and resp_err SHALL hold their values until the next RESP.
REQ-029 cp_ack outside REQ SHALL be ignored.
REQ-030 stall SHALL be 1 in REQ and RESP, and 0 in IDLE.
REQ-031 The design SHALL be back-to-back capable: a command presented in the IDLE cycle following RESP is accepted.

Reset
REQ-032 rst SHALL force IDLE at the next edge, from any state including mid-REQ.
REQ-033 After reset: cp_req=0, resp_valid=0, resp_err=0, stall=0, cmd_ready=1, cp_inst=0, cp_wdata=0, resp_data=0, resp_flags=0, timeout counter=0.
REQ-034 A cp_ack arriving during or after reset for an aborted request SHALL produce no response.

Configuration
REQ-035 With macro CP1_TIMEOUT_EN defined: a counter clears on REQ entry and increments each REQ cycle without cp_ack.
REQ-036 With CP1_TIMEOUT_EN defined: on reaching TIMEOUT_CYCLES, go REQ->RESP with resp_err=1, resp_data=0, resp_flags=0; cp_ack in that same cycle takes priority (normal response).
REQ-037 Without CP1_TIMEOUT_EN: no counter; REQ waits indefinitely; resp_err arises only from non-COP1 commands.

Verification
REQ-038 MFC1 inst 0x44020800, cp_ack on 3rd REQ cycle with cp_rdata=0x3F800000, cp_flags=0x01 -> one resp_valid pulse, resp_data=0x3F800000, resp_flags=0x01, resp_err=0.
REQ-039 MTC1 inst 0x44821000, cmd_wdata=0xDEADBEEF, cp_ack on 1st REQ cycle -> cp_wdata=0xDEADBEEF while cp_req, resp_data=0, resp_valid at accept edge+2.
REQ-040 Non-COP1 inst 0x00000020 -> no cp_req, resp_valid with resp_err=1 one cycle after accept.
REQ-041 rst asserted on 2nd REQ cycle, cp_ack pulsed the following cycle -> IDLE, cp_req=0, no resp_valid.
REQ-042 CP1_TIMEOUT_EN, TIMEOUT_CYCLES=4, cp_ack never asserted -> resp_valid with resp_err=1 after 4 REQ cycles; without macro, stall stays 1 for 100 cycles.
REQ-043 Two COP1 commands back-to-back with immediate ack -> both accepted, two resp_valid pulses 3 cycles apart, stall low only in the IDLE cycle between.
